// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Constants that the register-file storage cells and the
//               register file itself must agree on.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    // Architectural data width of every general-purpose register
    localparam int XLEN       = 32;
    // Register index width and register count
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    // Index of the hard-wired zero register
    localparam int ZERO_REG   = 0;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // True for the hard-wired zero register; the register file ties that
    // instance to in = 0, load = 1
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return (int'(addr) == ZERO_REG);
    endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/mod_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_reg_if
// Description : Data/enable bundle of one register-file storage cell.
//               master drives in/load and reads out; slave is the cell.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_reg_if
    import rf_pkg::*;
#(
    parameter int WIDTH = XLEN
);

    logic [WIDTH-1:0] in;    // data to capture
    logic             load;  // capture enable, level-sampled at the clock edge
    logic [WIDTH-1:0] out;   // registered contents

    modport master (
        output in,
        output load,
        input  out
    );

    modport slave (
        input  in,
        input  load,
        output out
    );

endinterface : mod_reg_if
`default_nettype wire

// File: rtl/mod_reg.sv
`default_nettype none
// ============================================================================
// Module      : mod_reg
// Description : Load-enabled register, the storage cell of the register file.
//               Captures bus.in on a rising clk edge while bus.load is high,
//               holds otherwise. Asynchronous active-low reset to RESET_VAL.
//               bus.out comes straight from the flops.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_reg
    import rf_pkg::*;
#(
    parameter int               WIDTH     = XLEN,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mod_reg_if.slave     bus
);

    logic [WIDTH-1:0] r_out;

    // Storage flops: async reset wins over everything; load acts as a
    // data-path enable rather than a clock gate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= RESET_VAL;
        end else if (bus.load) begin
            r_out <= bus.in;
        end
    end

    // No combinational path from in/load: out is the flop output only
    assign bus.out = r_out;

endmodule : mod_reg
`default_nettype wire

// File: tb/tb_mod_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_reg
// Description : Self-checking bench for mod_reg. Four instances: default
//               32-bit, 32-bit with non-zero reset value, x0-style (in = 0,
//               load = 1) and 64-bit. Expected values come from a simple
//               "last value loaded at an edge" model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_reg;
    import rf_pkg::*;

    localparam logic [31:0] RV_R = 32'hCAFE_F00D;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mod_reg_if #(.WIDTH(32)) bus_a ();
    mod_reg_if #(.WIDTH(32)) bus_r ();
    mod_reg_if #(.WIDTH(32)) bus_z ();
    mod_reg_if #(.WIDTH(64)) bus_w ();

    mod_reg u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mod_reg #(.WIDTH(32), .RESET_VAL(RV_R)) u_r (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_r)
    );

    mod_reg u_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_z)
    );

    mod_reg #(.WIDTH(64)) u_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what each register should currently hold
    logic [31:0] exp_a, exp_r, exp_z;
    logic [63:0] exp_w;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk32({tag, "/a"}, bus_a.out, exp_a);
        chk32({tag, "/r"}, bus_r.out, exp_r);
        chk32({tag, "/z"}, bus_z.out, exp_z);
        chk64({tag, "/w"}, bus_w.out, exp_w);
    endtask

    // Assert reset asynchronously; model snaps to the reset values at once
    task automatic do_reset();
        rst_n = 1'b0;
        exp_a = '0;
        exp_r = RV_R;
        exp_z = '0;
        exp_w = '0;
    endtask

    // Advance one rising edge: whatever load/in hold at the edge decide the
    // new expected value; outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (rst_n === 1'b1) begin
            if (bus_a.load) exp_a = bus_a.in;
            if (bus_r.load) exp_r = bus_r.in;
            if (bus_z.load) exp_z = bus_z.in;
            if (bus_w.load) exp_w = bus_w.in;
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] d32, input logic ld, input logic [63:0] d64);
        bus_a.in   = d32;
        bus_a.load = ld;
        bus_r.in   = ~d32;
        bus_r.load = ld;
        bus_w.in   = d64;
        bus_w.load = ld;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        bus_z.in   = '0;
        bus_z.load = 1'b1;
        drive(32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset: out falls before any clock edge and stays there
        #1 do_reset();
        #1 check_all("reset_async");
        tick();
        check_all("reset_c1");
        tick();
        check_all("reset_c2");

        // Load: new value visible only after the edge
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'hDEAD_BEEF, 1'b1, 64'h0123_4567_89AB_CDEF);
        #1 check_all("load_before");
        tick();
        check_all("load_after");
        chk32("load_value", bus_a.out, 32'hDEAD_BEEF);
        chk64("load_value64", bus_w.out, 64'h0123_4567_89AB_CDEF);

        // Hold: load low, in changes and load glitches between edges
        @(negedge clk);
        drive(32'h1234_5678, 1'b0, 64'h1234_5678_9ABC_DEF0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("hold");
            @(negedge clk);
            #1 drive($urandom, 1'b1, {$urandom, $urandom});
            #1 drive($urandom, 1'b0, {$urandom, $urandom});
        end
        chk32("hold_value", bus_a.out, 32'hDEAD_BEEF);

        // Back-to-back loads, each lagging by one cycle
        for (int v = 1; v <= 3; v++) begin
            @(negedge clk);
            drive(32'(v), 1'b1, 64'(v) << 32);
            #1 check_all("b2b_pre");
            tick();
            check_all("b2b");
            chk32("b2b_value", bus_a.out, 32'(v));
        end

        // Async reset mid-cycle with load still high
        @(negedge clk);
        drive(32'hA5A5_A5A5, 1'b1, 64'hA5A5_A5A5_5A5A_5A5A);
        tick();
        check_all("async_loaded");
        #2 do_reset();
        #1 check_all("async_mid");
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'd7, 1'b1, 64'd7);
        #1 check_all("async_rel");
        tick();
        check_all("async_cap");
        chk32("async_value", bus_a.out, 32'd7);

        // Randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                do_reset();
                #1 check_all("rand_rst");
                #1 rst_n = 1'b1;
            end
            drive($urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom});
            tick();
            check_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mod_reg
`default_nettype wire
